// File: rtl/tick_period_meter.sv
// Measures the clk-cycle spacing between rising edges of an asynchronous tick and
// reports the last period as packed BCD, saturating at all nines with an overflow flag.
module tick_period_meter #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_in,
  input  logic                  enable,
  output logic [4*DIGITS-1:0]   period_bcd,
  output logic                  valid,
  output logic                  overflow,
  output logic                  busy
);

  localparam int unsigned W = 4 * DIGITS;
  localparam logic [W-1:0] FullScale = {DIGITS{4'h9}};
  localparam logic [W-1:0] CntOne    = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {StIdle, StMeasure} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   tick_edge;
  logic [W-1:0]           cnt_q, cnt_d;
  logic                   sat_q, sat_d;
  logic [W-1:0]           period_q, period_d;
  logic                   ovf_q, ovf_d;
  logic                   valid_q, valid_d;
  logic                   busy_q;

  // Ripple-carry increment across cascaded BCD digits.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign tick_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    period_d = period_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        sat_d = 1'b0;
        if (enable && tick_edge) begin
          cnt_d   = CntOne;
          state_d = StMeasure;
        end
      end
      StMeasure: begin
        // Losing enable wins over a coincident edge: abort without a result.
        if (!enable) begin
          state_d = StIdle;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end else if (tick_edge) begin
          period_d = cnt_q;
          ovf_d    = sat_q;
          valid_d  = 1'b1;
          cnt_d    = CntOne;
          sat_d    = 1'b0;
        end else if (cnt_q == FullScale) begin
          sat_d = 1'b1;
        end else begin
          cnt_d = bcd_inc(cnt_q);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        sat_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      period_q <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      period_q <= period_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      busy_q   <= (state_d == StMeasure);
    end
  end

  assign period_bcd = period_q;
  assign overflow   = ovf_q;
  assign valid      = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter: expected results are queued as ticks are driven
// and compared when valid pulses.
`timescale 1ns/1ps
module tb_tick_period_meter;

  logic        clk;
  logic        rst_n;
  logic        tick_in;
  logic        enable;
  logic [15:0] period_bcd;
  logic        valid;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int fails  = 0;
  int ph;
  logic [16:0] exp_q[$];

  tick_period_meter #(
    .DIGITS      (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_in    (tick_in),
    .enable     (enable),
    .period_bcd (period_bcd),
    .valid      (valid),
    .overflow   (overflow),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_result(input logic [15:0] bcd, input logic ovf);
    exp_q.push_back({ovf, bcd});
  endtask

  // Starts at a negedge, raises tick ph ns later, holds it hi cycles, ends n cycles later.
  task automatic pulse(input int n, input int hi, input int phase);
    if (phase > 0) #(phase);
    tick_in = 1'b1;
    repeat (hi) @(negedge clk);
    if (phase > 0) #(phase);
    tick_in = 1'b0;
    repeat (n - hi) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && valid) begin
      logic [16:0] e;
      chk("valid_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("period_bcd", 32'(period_bcd), 32'(e[15:0]));
        chk("overflow", 32'(overflow), 32'(e[16]));
        chk("busy_at_valid", 32'(busy), 32'd1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    tick_in = 1'b0;
    enable  = 1'b0;
    #2;
    chk("reset_period", 32'(period_bcd), 32'h0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;

    // Divide-by-5: first edge only starts timing.
    pulse(5, 1, 0);
    chk("busy_after_first", 32'(busy), 32'd1);
    repeat (4) begin
      expect_result(16'h0005, 1'b0);
      pulse(5, 1, 0);
    end

    // Digit carries, long-high levels, minimum period, overflow and recovery.
    expect_result(16'h0005, 1'b0);
    pulse(37, 10, 0);
    expect_result(16'h0037, 1'b0);
    pulse(1234, 10, 0);
    expect_result(16'h1234, 1'b0);
    pulse(2, 1, 0);
    expect_result(16'h0002, 1'b0);
    pulse(10007, 10, 0);
    expect_result(16'h9999, 1'b1);
    pulse(8, 1, 0);
    expect_result(16'h0008, 1'b0);
    pulse(5, 1, 0);

    // Enable drop a few cycles after an edge: outputs hold, no result.
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_period_hold", 32'(period_bcd), 32'h0008);
    chk("drop_overflow_hold", 32'(overflow), 32'd0);
    chk("drop_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    enable = 1'b1;
    pulse(6, 1, 0);
    chk("reenable_busy", 32'(busy), 32'd1);
    chk("reenable_hold", 32'(period_bcd), 32'h0008);
    expect_result(16'h0006, 1'b0);
    pulse(6, 1, 0);

    // Edge arriving in the same cycle enable falls is ignored.
    tick_in = 1'b1;
    @(negedge clk);
    tick_in = 1'b0;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("simul_busy", 32'(busy), 32'd0);
    chk("simul_period_hold", 32'(period_bcd), 32'h0006);
    repeat (4) @(negedge clk);
    chk("simul_queue_empty", 32'(exp_q.size()), 32'd0);

    // Random (but fixed) tick phase relative to clk.
    ph = int'($urandom_range(1, 9));
    if (ph == 5) ph = 4;
    enable = 1'b1;
    pulse(7, 2, ph);
    expect_result(16'h0007, 1'b0);
    pulse(7, 2, ph);
    expect_result(16'h0007, 1'b0);
    pulse(7, 2, ph);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("phase_queue_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of a period.
    enable = 1'b1;
    pulse(5, 1, 0);
    expect_result(16'h0005, 1'b0);
    pulse(5, 1, 0);
    chk("pre_reset_period", 32'(period_bcd), 32'h0005);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_period", 32'(period_bcd), 32'h0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse(5, 1, 0);
    chk("post_reset_period", 32'(period_bcd), 32'h0);
    expect_result(16'h0005, 1'b0);
    pulse(5, 1, 0);
    repeat (3) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/tick_period_meter.md
# tick_period_meter

Measures the spacing between consecutive rising edges of a tick input, in `clk` cycles, and reports it as packed BCD. It is the inverse of our clock-enable dividers: a divider turns a count into a periodic tick, and this block turns a periodic tick back into a count. It sits beside the BCD counter/display path, so a divider's output or an external pulse can be checked on the seven-segment digits.

## Interface
- `DIGITS`, default 4: number of BCD digits in the period counter; full scale is 10^DIGITS−1.
- `SYNC_STAGES`, default 2: flip-flop stages in the tick_in synchronizer; minimum 2.
- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `tick_in`  in  1: tick to measure; may be asynchronous to `clk`; any duty cycle.
- `enable`  in  1: measurement enable, synchronous, level.
- `period_bcd`  out  4*DIGITS: last measured period; packed BCD, most significant digit in the top nibble.
- `valid`  out  1: one-cycle pulse; `period_bcd` and `overflow` were updated this cycle.
- `overflow`  out  1: the last measured period exceeded full scale.
- `busy`  out  1: high while a period is being timed (state MEASURE).

## Operation
- **Synchronizer:** `tick_in` passes through `SYNC_STAGES` flops, then a history flop. `edge` = synced & ~history. Only 0→1 transitions count; a level held high yields one edge.
- **Period counter:** DIGITS cascaded BCD digits. Each digit goes 0–9; a digit carries into the next when it is 9 and increments.
- **Saturation:** when every digit is 9, the counter holds. An internal `sat` flag sets.
- **FSM states:**
  - IDLE: counter = 0, `sat` = 0. If `enable` and `edge`: load counter with 1, go to MEASURE.
  - MEASURE, `enable` low: go to IDLE and clear the counter. Outputs hold their last values; no `valid`.
  - MEASURE, `edge`:
    - `period_bcd` <= counter.
    - `overflow` <= `sat`.
    - `valid` <= 1.
    - counter <= 1, `sat` <= 0.
    - Stay in MEASURE.
  - MEASURE, no `edge`: counter increments, or saturates and sets `sat`.
- **Period definition:** edges N cycles apart give `period_bcd` = N in BCD. Example: one tick every 5 cycles gives 0x0005.
- **Minimum period:** a rising edge needs one synced-low cycle in between, so the minimum measurable period is 2. This is a property of the design, not an error.
- **First edge:** the first edge after reset or after `enable` rises only starts timing and does not produce `valid`.
- **Edge and enable drop together:** an edge in the same cycle that `enable` falls is ignored. Go to IDLE; no `valid`.
- **Overflow reporting:** on overflow, `period_bcd` reports all 9s (0x9999 for DIGITS=4) with `overflow`=1. The next in-range measurement clears `overflow`.

## Timing
- **Reset values:** `period_bcd`=0, `valid`=0, `overflow`=0, `busy`=0, FSM=IDLE, counter=0, `sat`=0, synchronizer and history flops=0.
- **Reset mid-measurement:** asynchronous abort to the values above. Release is synchronous to `clk`.
- **Input latency:** a `tick_in` rising edge that meets setup before clk edge k produces `edge` in the cycle after edge k+SYNC_STAGES−1. The latency is identical for every edge, so measured periods are unaffected.
- **Output latency:** `valid`, `period_bcd` and `overflow` are registered. They change on the clock edge that samples `edge`=1.
- **Pulse and hold:**
  - `valid` is high for exactly one cycle per measurement.
  - `period_bcd` and `overflow` hold until the next `valid` or reset.
- **busy:** registered from the FSM state. It rises on the edge that enters MEASURE and falls on the edge that leaves it.
- **Throughput:** one result per input period; no gaps or back-pressure.

## Test plan
- **Divide-by-5 tick:** reset, `enable`=1, `tick_in` = 1-cycle pulse every 5 cycles → first edge produces no `valid`. Then `valid` every 5 cycles with `period_bcd`=0x0005 and `overflow`=0; `busy`=1 throughout.
- **Digit carries:** periods of 37, 1234 and 2, with `tick_in` held high 10 cycles per period where the period allows → 0x0037, 0x1234, 0x0002. Each is a single `valid` per period; the long-high pulses prove a level counts only once.
- **Overflow:** period 10007 → `period_bcd`=0x9999, `overflow`=1. Next period 8 → 0x0008, `overflow`=0.
- **Enable drop:** drop `enable` 3 cycles after an edge → `busy` falls, no `valid`, outputs hold their previous values. Re-enable with an edge 2 cycles later → no `valid` until one full period later.
- **Asynchronous reset:** assert `rst_n` low mid-period while `period_bcd`=0x0005 → all outputs go to 0 immediately. After release, the first edge produces no `valid`.
- **Simultaneous events:** an edge in the same cycle `enable` falls → no `valid`, FSM goes to IDLE. Randomized `tick_in` phase relative to `clk` → measured period equals the nominal period.
